// File: rtl/can_seq_pkg.sv
// Shared constants, descriptor type and TX-buffer byte helpers for the CAN TX sequencer.
package can_seq_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_TBS = 3'd1;
  localparam logic [2:0] S_WR_BUF   = 3'd2;
  localparam logic [2:0] S_WR_CMD   = 3'd3;
  localparam logic [2:0] S_WAIT_TCS = 3'd4;
  localparam logic [2:0] S_ABORT    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [1:0] RES_OK      = 2'b00;
  localparam logic [1:0] RES_TIMEOUT = 2'b01;
  localparam logic [1:0] RES_BUS_OFF = 2'b10;
  localparam logic [1:0] RES_WB_ERR  = 2'b11;

  localparam int STAT_TBS = 2;
  localparam int STAT_TCS = 3;
  localparam int STAT_BS  = 7;

  localparam logic [7:0] CMD_TR = 8'h01;
  localparam logic [7:0] CMD_AT = 8'h02;

  typedef struct packed {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } can_desc_t;

  // Number of TX-buffer bytes written: header pair plus payload clipped to 8.
  function automatic logic [3:0] tx_len(input can_desc_t d);
    logic [3:0] n;
    if (d.rtr)             n = 4'd2;
    else if (d.dlc > 4'd8) n = 4'd10;
    else                   n = 4'd2 + d.dlc;
    return n;
  endfunction

  // Byte written at TXBUF_BASE+idx; payload byte 0 lives in data[63:56].
  function automatic logic [7:0] txbuf_byte(input can_desc_t d, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = d.id[10:3];
      4'd1:    b = {d.id[2:0], d.rtr, d.dlc};
      default: b = 8'(d.data >> {4'd9 - idx, 3'b000});
    endcase
    return b;
  endfunction

endpackage

// File: rtl/can_wb_access.sv
// Single Wishbone access engine: holds one registered access until ack or ack timeout.
module can_wb_access #(
  parameter int ACK_LIMIT = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [7:0] adr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic       m_cyc_o,
  output logic       m_stb_o,
  output logic       m_we_o,
  output logic [7:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i
);

  localparam int AW = $clog2(ACK_LIMIT + 1);

  logic [AW-1:0] ack_cnt_q;
  logic          cyc_q, we_q, done_q, err_q;
  logic [7:0]    adr_q, dat_q, rdata_q;

  // Launch on start, retire on ack (capturing read data) or on ack timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      ack_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cyc_q) begin
        if (m_ack_i) begin
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          adr_q   <= '0;
          dat_q   <= '0;
          done_q  <= 1'b1;
          rdata_q <= m_dat_i;
        end else if (ack_cnt_q >= AW'(ACK_LIMIT - 1)) begin
          cyc_q <= 1'b0;
          we_q  <= 1'b0;
          adr_q <= '0;
          dat_q <= '0;
          err_q <= 1'b1;
        end else begin
          ack_cnt_q <= ack_cnt_q + 1'b1;
        end
      end else if (start_i) begin
        cyc_q     <= 1'b1;
        we_q      <= we_i;
        adr_q     <= adr_i;
        dat_q     <= wdata_i;
        ack_cnt_q <= '0;
      end
    end
  end

  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;
  assign m_we_o  = we_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/can_tx_sequencer.sv
// Frame-level sequencer: wait TBS, load TX buffer, request TX, poll TCS, report result.
module can_tx_sequencer
  import can_seq_pkg::*;
#(
  parameter int TXBUF_BASE = 10,
  parameter int CMD_ADDR   = 1,
  parameter int STAT_ADDR  = 2,
  parameter int POLL_LIMIT = 1024,
  parameter int ACK_LIMIT  = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [10:0] req_id_i,
  input  logic        req_rtr_i,
  input  logic [3:0]  req_dlc_i,
  input  logic [63:0] req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  result_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [7:0]  m_adr_o,
  output logic [7:0]  m_dat_o,
  input  logic [7:0]  m_dat_i,
  input  logic        m_ack_i
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  logic [2:0]    state_q, state_d;
  can_desc_t     desc_q, desc_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    result_q, result_d;
  logic          done_q;

  logic          acc_start, acc_we, acc_done, acc_err;
  logic [7:0]    acc_adr, acc_wdata, acc_rdata;
  logic          poll_last;
  logic          unused_rdata;

  assign poll_last    = (poll_q >= PW'(POLL_LIMIT - 1));
  assign unused_rdata = ^{acc_rdata[6:4], acc_rdata[1:0]};

  can_wb_access #(.ACK_LIMIT(ACK_LIMIT)) u_acc (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .start_i (acc_start),
    .we_i    (acc_we),
    .adr_i   (acc_adr),
    .wdata_i (acc_wdata),
    .done_o  (acc_done),
    .err_o   (acc_err),
    .rdata_o (acc_rdata),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_dat_i (m_dat_i),
    .m_ack_i (m_ack_i)
  );

  // Next access is launched in the cycle the previous one retires, keeping a 3-cycle cadence.
  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    poll_d    = poll_q;
    idx_d     = idx_q;
    result_d  = result_q;
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = 8'(STAT_ADDR);
    acc_wdata = 8'h00;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        desc_d    = '{id: req_id_i, rtr: req_rtr_i, dlc: req_dlc_i, data: req_data_i};
        poll_d    = '0;
        acc_start = 1'b1;
        state_d   = S_WAIT_TBS;
      end
      S_WAIT_TBS: if (acc_done) begin
        if (acc_rdata[STAT_BS]) begin
          state_d  = S_DONE;
          result_d = RES_BUS_OFF;
        end else if (acc_rdata[STAT_TBS]) begin
          state_d   = S_WR_BUF;
          idx_d     = '0;
          acc_start = 1'b1;
          acc_we    = 1'b1;
          acc_adr   = 8'(TXBUF_BASE);
          acc_wdata = txbuf_byte(desc_q, 4'd0);
        end else if (poll_last) begin
          state_d  = S_DONE;
          result_d = RES_TIMEOUT;
        end else begin
          poll_d    = poll_q + 1'b1;
          acc_start = 1'b1;
        end
      end
      S_WR_BUF: if (acc_done) begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        if (idx_q == tx_len(desc_q) - 4'd1) begin
          state_d   = S_WR_CMD;
          acc_adr   = 8'(CMD_ADDR);
          acc_wdata = CMD_TR;
        end else begin
          idx_d     = idx_q + 4'd1;
          acc_adr   = 8'(TXBUF_BASE) + {4'd0, idx_d};
          acc_wdata = txbuf_byte(desc_q, idx_d);
        end
      end
      S_WR_CMD: if (acc_done) begin
        poll_d    = '0;
        state_d   = S_WAIT_TCS;
        acc_start = 1'b1;
      end
      S_WAIT_TCS: if (acc_done) begin
        if (acc_rdata[STAT_BS]) begin
          state_d  = S_DONE;
          result_d = RES_BUS_OFF;
        end else if (acc_rdata[STAT_TCS]) begin
          state_d  = S_DONE;
          result_d = RES_OK;
        end else if (poll_last) begin
          state_d   = S_ABORT;
          acc_start = 1'b1;
          acc_we    = 1'b1;
          acc_adr   = 8'(CMD_ADDR);
          acc_wdata = CMD_AT;
        end else begin
          poll_d    = poll_q + 1'b1;
          acc_start = 1'b1;
        end
      end
      S_ABORT: if (acc_done) begin
        state_d  = S_DONE;
        result_d = RES_TIMEOUT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A stuck slave ends the frame with no further bus traffic.
    if (acc_err) begin
      state_d   = S_DONE;
      result_d  = RES_WB_ERR;
      acc_start = 1'b0;
    end
  end

  // State, captured descriptor, counters and the registered completion outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      desc_q   <= '0;
      poll_q   <= '0;
      idx_q    <= '0;
      result_q <= RES_OK;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      poll_q   <= poll_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= (state_d == S_DONE);
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_can_tx_sequencer.sv
// Randomized + directed bench for can_tx_sequencer against a transaction-level reference model.
module tb_can_tx_sequencer;

  localparam int POLL = 4;
  localparam int ACKL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_rtr = 1'b0;
  logic [10:0] req_id = '0;
  logic [3:0]  req_dlc = '0;
  logic [63:0] req_data = '0;
  logic        busy, done;
  logic [1:0]  result;
  logic        m_cyc, m_stb, m_we;
  logic        m_ack = 1'b0;
  logic [7:0]  m_adr, m_dat_o;
  logic [7:0]  m_dat_in = '0;

  always #5 clk = ~clk;

  can_tx_sequencer #(.TXBUF_BASE(10), .CMD_ADDR(1), .STAT_ADDR(2),
                     .POLL_LIMIT(POLL), .ACK_LIMIT(ACKL)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_id_i(req_id), .req_rtr_i(req_rtr), .req_dlc_i(req_dlc), .req_data_i(req_data),
    .busy_o(busy), .done_o(done), .result_o(result),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_adr_o(m_adr), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_in), .m_ack_i(m_ack)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int   slv_tbs = 0, slv_tcs = 0, slv_bs_ph = -1, slv_bs_at = 0;
  bit   slv_noack = 1'b0;
  int   rd_cnt = 0, phase = 0, cyc_run = 0, last_run = 0, done_cnt = 0;
  logic seen = 1'b0;
  logic [16:0] act_q[$];

  function automatic logic [7:0] stat_val();
    if (phase == 0) begin
      if (slv_bs_ph == 0 && rd_cnt == slv_bs_at) return 8'h80;
      return (rd_cnt >= slv_tbs) ? 8'h04 : 8'h00;
    end
    if (slv_bs_ph == 1 && rd_cnt == slv_bs_at) return 8'h84;
    return (rd_cnt >= slv_tcs) ? 8'h0C : 8'h04;
  endfunction

  // Acks one cycle after stb, logs every acked access, tracks phase by the TR write.
  always @(negedge clk) begin
    if (!rst_n || !busy) begin rd_cnt = 0; phase = 0; end
    if (!busy) last_run = 0;
    if (m_cyc) cyc_run++;
    else begin
      if (cyc_run != 0) last_run = cyc_run;
      cyc_run = 0;
    end
    if (done) done_cnt++;
    if (!rst_n) begin
      m_ack = 1'b0; seen = 1'b0;
    end else if (m_cyc && m_stb && !slv_noack) begin
      if (!seen) seen = 1'b1;
      else if (!m_ack) begin
        m_ack = 1'b1;
        if (m_we) begin
          act_q.push_back({1'b1, m_adr, m_dat_o});
          if (m_adr == 8'd1 && m_dat_o == 8'h01) begin phase = 1; rd_cnt = 0; end
        end else begin
          m_dat_in = stat_val();
          rd_cnt++;
          act_q.push_back({1'b0, m_adr, 8'h00});
        end
      end
    end else begin
      m_ack = 1'b0; seen = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [16:0] exp_q[$];

  function automatic logic [16:0] mk(input bit we, input int adr, input int dat);
    return {we, 8'(adr), 8'(dat)};
  endfunction

  function automatic void build_exp(input int id, input int rtr, input int dlc, input logic [63:0] data,
                                    input int tbs, input int tcs, input int bsph, input int bsat,
                                    output int res);
    int r, nd;
    exp_q.delete();
    res = 0;
    for (r = 0; r < POLL; r++) begin
      exp_q.push_back(mk(0, 2, 0));
      if (bsph == 0 && r == bsat) begin res = 2; return; end
      if (r >= tbs) break;
      if (r + 1 == POLL) begin res = 1; return; end
    end
    nd = rtr ? 0 : (dlc > 8 ? 8 : dlc);
    exp_q.push_back(mk(1, 10, id / 8));
    exp_q.push_back(mk(1, 11, (id % 8) * 32 + rtr * 16 + dlc));
    for (int j = 0; j < nd; j++) exp_q.push_back(mk(1, 12 + j, int'((data >> (56 - 8 * j)) & 64'hFF)));
    exp_q.push_back(mk(1, 1, 1));
    for (r = 0; r < POLL; r++) begin
      exp_q.push_back(mk(0, 2, 0));
      if (bsph == 1 && r == bsat) begin res = 2; return; end
      if (r >= tcs) begin res = 0; return; end
    end
    exp_q.push_back(mk(1, 1, 2));
    res = 1;
  endfunction

  // ---------------- frame driver ----------------
  task automatic run_frame(input string nm, input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                           input logic [63:0] data, input int tbs, input int tcs, input int bsph,
                           input int bsat, input bit noack);
    int base, k, res, n;
    slv_tbs = tbs; slv_tcs = tcs; slv_bs_ph = bsph; slv_bs_at = bsat; slv_noack = noack;
    build_exp(int'(id), int'(rtr), int'(dlc), data, tbs, tcs, bsph, bsat, res);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    base = act_q.size();
    req_valid = 1'b1; req_id = id; req_rtr = rtr; req_dlc = dlc; req_data = data;
    chk({nm, ":ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_id = 11'($urandom); req_rtr = 1'($urandom); req_dlc = 4'($urandom);
    req_data = {$urandom, $urandom};
    chk({nm, ":busy"}, busy, 1);
    k = 1;
    while (!done && k < 3000) begin @(negedge clk); k++; end
    chk({nm, ":done_seen"}, done, 1);
    chk({nm, ":ready_in_done"}, req_ready, 0);
    if (noack) begin
      chk({nm, ":result"}, result, 3);
      chk({nm, ":cyc_cycles"}, last_run, ACKL);
      chk({nm, ":n_acc"}, act_q.size() - base, 0);
    end else begin
      chk({nm, ":result"}, result, res);
      chk({nm, ":latency"}, k, 3 * exp_q.size() + 1);
      n = act_q.size() - base;
      chk({nm, ":n_acc"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
        chk($sformatf("%s:acc%0d", nm, i), act_q[base + i], exp_q[i]);
    end
    @(negedge clk);
    chk({nm, ":done_pulse"}, done, 0);
    chk({nm, ":result_hold"}, result, noack ? 3 : res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    bit found;
    #3;
    chk("rst:ready", req_ready, 1);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:result", result, 0);
    chk("rst:bus", {m_cyc, m_stb, m_we, m_adr, m_dat_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame("basic",   11'h123, 1'b0, 4'd2,  64'hAABB_0000_0000_0000, 0, 1, -1, 0, 0);
    run_frame("rtr",     11'h7FF, 1'b1, 4'd8,  64'h0123_4567_89AB_CDEF, 0, 0, -1, 0, 0);
    run_frame("dlc12",   11'h055, 1'b0, 4'd12, 64'h1122_3344_5566_7788, 1, 0, -1, 0, 0);
    run_frame("tcs_to",  11'h001, 1'b0, 4'd1,  64'h5A00_0000_0000_0000, 0, 99, -1, 0, 0);
    run_frame("tbs_to",  11'h400, 1'b0, 4'd3,  64'hDEAD_BEEF_0000_0000, 99, 0, -1, 0, 0);
    run_frame("busoff0", 11'h2AA, 1'b0, 4'd4,  64'hCAFE_F00D_0000_0000, 0, 0, 0, 0, 0);
    run_frame("busoff1", 11'h155, 1'b0, 4'd0,  64'h0, 0, 3, 1, 1, 0);
    run_frame("noack",   11'h0F0, 1'b0, 4'd2,  64'h1234_0000_0000_0000, 0, 0, -1, 0, 1);

    for (int i = 0; i < 30; i++) begin
      int bp;
      bp = $urandom_range(0, 5);
      run_frame($sformatf("rnd%0d", i), 11'($urandom), 1'($urandom_range(0, 3) == 0),
                4'($urandom), {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 4),
                bp < 2 ? bp : -1, $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of the buffer load.
    slv_tbs = 0; slv_tcs = 0; slv_bs_ph = -1; slv_noack = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_id = 11'h321; req_rtr = 1'b0; req_dlc = 4'd8; req_data = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (m_cyc && m_we && m_adr == 8'd12) found = 1'b1;
      else @(negedge clk);
    end
    chk("rstmid:reached_wrbuf", found, 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid:cyc_async", {m_cyc, m_stb}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid:ready", req_ready, 1);
    chk("rstmid:no_done", done_cnt, d0);
    chk("rstmid:bus_idle", m_cyc, 0);

    run_frame("post_rst", 11'h3C3, 1'b0, 4'd5, 64'h0102_0304_0500_0000, 2, 2, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
